// File: rtl/cpu.sv
// Single-cycle 32-bit MIPS-subset core with a loadable instruction memory.
// Architectural state is visible to the bench as pc, regs and dmem.
module cpu #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        initialize,
  input  logic [31:0] instruction_initialize_data,
  input  logic [31:0] instruction_initialize_address
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [31:0] imem_q [0:IMEM_WORDS-1];
  logic [31:0] regs_q [0:31];
  logic [31:0] dmem_q [0:DMEM_WORDS-1];
  logic [31:0] pc_q, pc_d;

  // Architectural names observed hierarchically.
  logic [31:0] pc;
  logic [31:0] regs [0:31];
  logic [31:0] dmem [0:DMEM_WORDS-1];
  assign pc   = pc_q;
  assign regs = regs_q;
  assign dmem = dmem_q;

  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] rs_val, rt_val, imm_sext, imm_zext;
  logic [31:0] pc_plus4, branch_target, mem_addr;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_we;

  assign instr    = imem_q[pc_q[IW+1:2]];
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign target   = instr[25:0];

  assign rs_val   = regs_q[rs];
  assign rt_val   = regs_q[rt];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign mem_addr      = rs_val + imm_sext;

  logic unused_bits;
  assign unused_bits = ^{instruction_initialize_address[31:IW+2],
                         instruction_initialize_address[1:0],
                         mem_addr[31:DW+2], mem_addr[1:0]};

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = 32'h0;
    mem_we   = 1'b0;
    pc_d     = pc_plus4;
    unique case (op)
      OP_RTYPE: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        unique case (funct)
          FN_ADD:  rf_wdata = rs_val + rt_val;
          FN_SUB:  rf_wdata = rs_val - rt_val;
          FN_AND:  rf_wdata = rs_val & rt_val;
          FN_OR:   rf_wdata = rs_val | rt_val;
          FN_NOR:  rf_wdata = ~(rs_val | rt_val);
          FN_SLT:  rf_wdata = {31'h0, $signed(rs_val) < $signed(rt_val)};
          default: rf_we    = 1'b0;
        endcase
      end
      OP_ADDI: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = rs_val + imm_sext;
      end
      OP_ANDI: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = rs_val & imm_zext;
      end
      OP_ORI: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = rs_val | imm_zext;
      end
      OP_SLTI: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = {31'h0, $signed(rs_val) < $signed(imm_sext)};
      end
      OP_LW: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = dmem_q[mem_addr[DW+1:2]];
      end
      OP_SW:   mem_we = 1'b1;
      OP_BEQ:  if (rs_val == rt_val) pc_d = branch_target;
      OP_BNE:  if (rs_val != rt_val) pc_d = branch_target;
      OP_J:    pc_d = {pc_plus4[31:28], target, 2'b00};
      default: ;
    endcase
    // Load mode freezes the core: nothing architectural may change.
    if (initialize) begin
      rf_we  = 1'b0;
      mem_we = 1'b0;
      pc_d   = pc_q;
    end
  end

  // Instruction memory has no reset so a program survives a core reset.
  always_ff @(posedge clk) begin
    if (initialize) begin
      imem_q[instruction_initialize_address[IW+1:2]] <= instruction_initialize_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= 32'h0;
      for (int k = 0; k < 32; k++) begin
        regs_q[k] <= 32'(k);
      end
      for (int k = 0; k < DMEM_WORDS; k++) begin
        dmem_q[k] <= 32'h0;
      end
    end else begin
      pc_q <= pc_d;
      if (rf_we && (rf_waddr != 5'd0)) begin
        regs_q[rf_waddr] <= rf_wdata;
      end
      if (mem_we) begin
        dmem_q[mem_addr[DW+1:2]] <= rt_val;
      end
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for the cpu core: single-instruction vector table from reset,
// then hand-written multi-cycle programs for sequencing, memory and reset.
module tb_cpu;

  logic        clk;
  logic        rst;
  logic        initialize;
  logic [31:0] instruction_initialize_data;
  logic [31:0] instruction_initialize_address;

  int n_checks;
  int n_pass;

  logic [31:0] prog_q[$];

  cpu dut (
    .clk                            (clk),
    .rst                            (rst),
    .initialize                     (initialize),
    .instruction_initialize_data    (instruction_initialize_data),
    .instruction_initialize_address (instruction_initialize_address)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          dst;
    logic [31:0] exp_val;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset, load prog_q from address 0, then release into run mode.
  task automatic load_prog(input bit release_core);
    rst = 1'b1;
    initialize = 1'b1;
    for (int i = 0; i < prog_q.size(); i++) begin
      instruction_initialize_address = 32'(i * 4);
      instruction_initialize_data    = prog_q[i];
      tick();
    end
    if (release_core) begin
      initialize = 1'b0;
      rst = 1'b0;
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input int dst,
                              input logic [31:0] v, input logic [31:0] p);
    vec_t r;
    r.instr = instr; r.dst = dst; r.exp_val = v; r.exp_pc = p;
    return r;
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    initialize = 1'b0;
    instruction_initialize_data = 32'h0;
    instruction_initialize_address = 32'h0;
    #2;

    // Operands after reset: regs[k] = k.
    vecs.push_back(mk(32'h00020820,  1, 32'h00000002, 32'd4));  // ADD r1,r0,r2
    vecs.push_back(mk(32'h00A93822,  7, 32'hFFFFFFFC, 32'd4));  // SUB r7,r5,r9
    vecs.push_back(mk(32'h018A4024,  8, 32'h00000008, 32'd4));  // AND r8,r12,r10
    vecs.push_back(mk(32'h01834025,  8, 32'h0000000F, 32'd4));  // OR  r8,r12,r3
    vecs.push_back(mk(32'h00004827,  9, 32'hFFFFFFFF, 32'd4));  // NOR r9,r0,r0
    vecs.push_back(mk(32'h0062502A, 10, 32'h00000000, 32'd4));  // SLT r10,r3,r2
    vecs.push_back(mk(32'h0043582A, 11, 32'h00000001, 32'd4));  // SLT r11,r2,r3
    vecs.push_back(mk(32'h20430001,  3, 32'h00000003, 32'd4));  // ADDI r3,r2,1
    vecs.push_back(mk(32'h2004FFFF,  4, 32'hFFFFFFFF, 32'd4));  // ADDI r4,r0,-1
    vecs.push_back(mk(32'h30E5FFFF,  5, 32'h00000007, 32'd4));  // ANDI r5,r7,0xFFFF
    vecs.push_back(mk(32'h34068000,  6, 32'h00008000, 32'd4));  // ORI r6,r0,0x8000
    vecs.push_back(mk(32'h286CFFFF, 12, 32'h00000000, 32'd4));  // SLTI r12,r3,-1
    vecs.push_back(mk(32'h286D0005, 13, 32'h00000001, 32'd4));  // SLTI r13,r3,5
    vecs.push_back(mk(32'h00220020,  0, 32'h00000000, 32'd4));  // ADD r0,r1,r2
    vecs.push_back(mk(32'h0022703F, 14, 32'h0000000E, 32'd4));  // bad funct
    vecs.push_back(mk(32'hFC0F0005, 15, 32'h0000000F, 32'd4));  // bad op
    vecs.push_back(mk(32'h1000FFFF,  1, 32'h00000001, 32'd0));  // BEQ r0,r0,-1
    vecs.push_back(mk(32'h10220003,  1, 32'h00000001, 32'd4));  // BEQ not taken
    vecs.push_back(mk(32'h14220003,  1, 32'h00000001, 32'd16)); // BNE taken
    vecs.push_back(mk(32'h08000010,  1, 32'h00000001, 32'h40)); // J 0x10
    vecs.push_back(mk(32'h8C060008,  6, 32'h00000000, 32'd4));  // LW from cleared dmem

    for (int i = 0; i < vecs.size(); i++) begin
      prog_q = {vecs[i].instr};
      load_prog(1'b1);
      tick();
      check($sformatf("vec%0d_reg%0d", i, vecs[i].dst), dut.regs[vecs[i].dst], vecs[i].exp_val);
      check($sformatf("vec%0d_pc", i), dut.pc, vecs[i].exp_pc);
    end

    // Load mode with rst held, then run the ADDI sequence into a BEQ self-loop.
    prog_q = {32'h00020820, 32'h20430001, 32'h20430002, 32'h20430003, 32'h1000FFFF};
    load_prog(1'b0);
    check("load_pc", dut.pc, 32'd0);
    check("load_r7", dut.regs[7], 32'd7);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("load_imem%0d", i), dut.imem_q[i], prog_q[i]);
    end
    initialize = 1'b0;
    rst = 1'b0;
    tick();
    check("seq_add_r1", dut.regs[1], 32'd2);
    check("seq_add_pc", dut.pc, 32'd4);
    tick(); check("seq_addi_r3_a", dut.regs[3], 32'd3);
    tick(); check("seq_addi_r3_b", dut.regs[3], 32'd4);
    tick(); check("seq_addi_r3_c", dut.regs[3], 32'd5);
    tick(); check("seq_beq_pc_a", dut.pc, 32'd16);
    tick(); check("seq_beq_pc_b", dut.pc, 32'd16);

    // Load with rst low: pc and registers hold while imem is written.
    initialize = 1'b1;
    instruction_initialize_address = 32'd20;
    instruction_initialize_data = 32'h00A53020;
    tick();
    tick();
    check("hold_pc", dut.pc, 32'd16);
    check("hold_r1", dut.regs[1], 32'd2);
    check("hold_r3", dut.regs[3], 32'd5);
    check("hold_imem5", dut.imem_q[5], 32'h00A53020);
    initialize = 1'b0;

    // Doubling to the sign bit, then wraparound and signed compare.
    prog_q = {32'h20080001};
    for (int i = 0; i < 31; i++) prog_q.push_back(32'h01084020);
    prog_q.push_back(32'h01005027);  // NOR r10,r8,r0
    prog_q.push_back(32'h214B0001);  // ADDI r11,r10,1
    prog_q.push_back(32'h01086020);  // ADD r12,r8,r8
    prog_q.push_back(32'h2004FFFF);  // ADDI r4,r0,-1
    prog_q.push_back(32'h0080282A);  // SLT r5,r4,r0
    load_prog(1'b1);
    for (int i = 0; i < 32; i++) tick();
    check("ovf_r8", dut.regs[8], 32'h80000000);
    tick(); check("ovf_nor_r10", dut.regs[10], 32'h7FFFFFFF);
    tick(); check("ovf_addi_r11", dut.regs[11], 32'h80000000);
    tick(); check("ovf_wrap_r12", dut.regs[12], 32'h00000000);
    tick(); check("neg_r4", dut.regs[4], 32'hFFFFFFFF);
    tick(); check("slt_neg_r5", dut.regs[5], 32'd1);

    // Store/load, read-before-write, address aliasing, then an idle loop.
    prog_q = {32'hAC020008, 32'h8C060008, 32'h00210820, 32'h00210820,
              32'hAC030408, 32'h8C070008, 32'h1000FFFF};
    load_prog(1'b1);
    tick(); check("sw_dmem2", dut.dmem[2], 32'd2);
    tick(); check("lw_r6", dut.regs[6], 32'd2);
    tick(); check("add_self_r1_a", dut.regs[1], 32'd2);
    tick(); check("add_self_r1_b", dut.regs[1], 32'd4);
    tick(); check("sw_alias_dmem2", dut.dmem[2], 32'd3);
    tick(); check("lw_alias_r7", dut.regs[7], 32'd3);
    tick(); tick();
    check("loop_pc", dut.pc, 32'd24);
    check("loop_r0", dut.regs[0], 32'd0);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check("areset_pc", dut.pc, 32'd0);
    check("areset_r1", dut.regs[1], 32'd1);
    check("areset_r6", dut.regs[6], 32'd6);
    check("areset_dmem2", dut.dmem[2], 32'd0);
    check("areset_imem0", dut.imem_q[0], 32'hAC020008);
    check("areset_imem6", dut.imem_q[6], 32'h1000FFFF);
    rst = 1'b0;
    tick();
    check("after_reset_dmem2", dut.dmem[2], 32'd2);
    check("after_reset_pc", dut.pc, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
